// File: rtl/mem_sequencer.sv
// mem_sequencer: a five-stage memory-driven sequencer. It fetches a
// two-word instruction (A, then B) from an external RAM and executes
// either a store (write B to A's address) or a load (read A's address
// into acc). An all-ones A word halts the sequencer and returns it to WAIT.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   run                 start request, honoured only in WAIT
//   waits/fetcha/fetchb/execa/execb  one-hot stage indicators (registered)
//   pc                  program counter, wraps modulo 2^ADDR_W
//   ira, irb            instruction registers A and B
//   acc                 result of the most recent load
//   halted              set when a halt word ends a run
//   instr_count         retired store/load count, wraps modulo 2^CNT_W
//   mem_addr/mem_wdata/mem_rden/mem_wren  RAM request bus
//   mem_rdata           RAM read data, valid in the cycle mem_rden is high
module mem_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              waits,
  output logic              fetcha,
  output logic              fetchb,
  output logic              execa,
  output logic              execb,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ira,
  output logic [DATA_W-1:0] irb,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One-hot encoding so each stage indicator is a state flop directly.
  typedef enum logic [4:0] {
    S_WAIT   = 5'b00001,
    S_FETCHA = 5'b00010,
    S_FETCHB = 5'b00100,
    S_EXECA  = 5'b01000,
    S_EXECB  = 5'b10000
  } state_t;

  localparam logic [DATA_W-1:0] HALT_WORD = '1;

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [DATA_W-1:0]   ira_reg;
  logic [DATA_W-1:0]   irb_reg;
  logic [DATA_W-1:0]   acc_reg;
  logic                halted_reg;
  logic [CNT_W-1:0]    count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_WAIT;
      pc_reg     <= '0;
      ira_reg    <= '0;
      irb_reg    <= '0;
      acc_reg    <= '0;
      halted_reg <= 1'b0;
      count_reg  <= '0;
    end else begin
      case (state_reg)
        S_WAIT: begin
          if (run) begin
            state_reg  <= S_FETCHA;
            halted_reg <= 1'b0;
          end
        end
        S_FETCHA: begin
          ira_reg   <= mem_rdata;
          pc_reg    <= pc_reg + 1'b1;
          state_reg <= S_FETCHB;
        end
        S_FETCHB: begin
          // The B word is still consumed for a halt pair so pc resumes
          // past it on the next run.
          irb_reg <= mem_rdata;
          pc_reg  <= pc_reg + 1'b1;
          if (ira_reg == HALT_WORD) begin
            state_reg  <= S_WAIT;
            halted_reg <= 1'b1;
          end else begin
            state_reg <= S_EXECA;
          end
        end
        S_EXECA: begin
          if (ira_reg[DATA_W-1]) begin
            acc_reg <= mem_rdata;
          end
          state_reg <= S_EXECB;
        end
        S_EXECB: begin
          count_reg <= count_reg + 1'b1;
          state_reg <= S_FETCHA;
        end
        default: state_reg <= S_WAIT;
      endcase
    end
  end

  // Memory bus decodes straight from the registered state, so a reset
  // seen during EXECA drops mem_wren in the very next cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rden  = 1'b0;
    mem_wren  = 1'b0;
    case (state_reg)
      S_FETCHA, S_FETCHB: begin
        mem_addr = pc_reg;
        mem_rden = 1'b1;
      end
      S_EXECA: begin
        mem_addr = ira_reg[ADDR_W-1:0];
        if (ira_reg[DATA_W-1]) begin
          mem_rden = 1'b1;
        end else begin
          mem_wdata = irb_reg;
          mem_wren  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign waits       = state_reg[0];
  assign fetcha      = state_reg[1];
  assign fetchb      = state_reg[2];
  assign execa       = state_reg[3];
  assign execb       = state_reg[4];
  assign pc          = pc_reg;
  assign ira         = ira_reg;
  assign irb         = irb_reg;
  assign acc         = acc_reg;
  assign halted      = halted_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed testbench for mem_sequencer (DATA_W=8, ADDR_W=7, CNT_W=16).
// A behavioural RAM is serviced on the falling edge inside the step task,
// so read data is ready for the next rising edge and writes land mid-cycle.
module tb_mem_sequencer;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int CNT_W  = 16;

  localparam logic [4:0] ST_W  = 5'b10000;
  localparam logic [4:0] ST_FA = 5'b01000;
  localparam logic [4:0] ST_FB = 5'b00100;
  localparam logic [4:0] ST_EA = 5'b00010;
  localparam logic [4:0] ST_EB = 5'b00001;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic              waits, fetcha, fetchb, execa, execb;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ira, irb, acc;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rden, mem_wren;
  logic [DATA_W-1:0] mem_rdata = '0;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_fail   = 0;

  mem_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run),
    .waits(waits), .fetcha(fetcha), .fetchb(fetchb), .execa(execa), .execb(execb),
    .pc(pc), .ira(ira), .irb(irb), .acc(acc), .halted(halted),
    .instr_count(instr_count),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one cycle, servicing the RAM at the falling edge; returns
  // 1 time unit after the rising edge.
  task automatic step();
    @(negedge clk);
    if (mem_wren) mem[mem_addr] = mem_wdata;
    if (mem_rden) mem_rdata = mem[mem_addr];
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] stages();
    return {waits, fetcha, fetchb, execa, execb};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_fetch(input string tag, input logic [4:0] st, input int addr);
    check({tag, "_stage"}, 32'(stages()), 32'(st));
    check({tag, "_addr"}, 32'(mem_addr), addr);
    check({tag, "_rw"}, {30'd0, mem_rden, mem_wren}, 32'b10);
  endtask

  bit found;

  initial begin
    clear_mem();
    step();
    do_reset();

    // Reset state
    check("rst_stage", 32'(stages()), 32'(ST_W));
    check("rst_rw", {30'd0, mem_rden, mem_wren}, 32'b00);
    check("rst_pc", 32'(pc), 0);
    check("rst_cnt", 32'(instr_count), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_acc", 32'(acc), 0);

    // Store then halt
    mem[0] = 8'h40; mem[1] = 8'h5A; mem[2] = 8'hFF; mem[3] = 8'h00;
    run = 1'b1;
    step();
    run = 1'b0;
    check_fetch("st_fa", ST_FA, 0);
    step();
    check_fetch("st_fb", ST_FB, 1);
    step();
    check("st_ea_stage", 32'(stages()), 32'(ST_EA));
    check("st_ea_rw", {30'd0, mem_rden, mem_wren}, 32'b01);
    check("st_ea_addr", 32'(mem_addr), 32'h40);
    check("st_ea_wdata", 32'(mem_wdata), 32'h5A);
    step();
    check("st_eb_stage", 32'(stages()), 32'(ST_EB));
    check("st_eb_bus", {22'd0, mem_rden, mem_wren, mem_addr, 1'b0}, 0);
    check("st_mem40", 32'(mem[8'h40]), 32'h5A);
    step();
    check_fetch("st_fa2", ST_FA, 2);
    check("st_cnt_mid", 32'(instr_count), 1);
    step();
    check_fetch("st_fb2", ST_FB, 3);
    step();
    check("st_halt_stage", 32'(stages()), 32'(ST_W));
    check("st_halted", 32'(halted), 1);
    check("st_pc", 32'(pc), 4);
    check("st_cnt", 32'(instr_count), 1);
    step();
    check("st_idle_stage", 32'(stages()), 32'(ST_W));

    // Resume after halt
    mem[4] = 8'h41; mem[5] = 8'h77; mem[6] = 8'hFF; mem[7] = 8'h00;
    run = 1'b1;
    step();
    run = 1'b0;
    check_fetch("rs_fa", ST_FA, 4);
    check("rs_halted_clr", 32'(halted), 0);
    step(); step(); step();
    check("rs_mem41", 32'(mem[8'h41]), 32'h77);
    step();
    check_fetch("rs_fa2", ST_FA, 6);
    step(); step();
    check("rs_stage", 32'(stages()), 32'(ST_W));
    check("rs_halted", 32'(halted), 1);
    check("rs_pc", 32'(pc), 8);
    check("rs_cnt", 32'(instr_count), 2);

    // Load
    do_reset();
    clear_mem();
    mem[0] = 8'hC0; mem[1] = 8'h00; mem[2] = 8'hFF; mem[3] = 8'h00; mem[8'h40] = 8'h33;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    step();
    check("ld_ea_stage", 32'(stages()), 32'(ST_EA));
    check("ld_ea_rw", {30'd0, mem_rden, mem_wren}, 32'b10);
    check("ld_ea_addr", 32'(mem_addr), 32'h40);
    step();
    check("ld_acc", 32'(acc), 32'h33);
    step(); step(); step();
    check("ld_stage", 32'(stages()), 32'(ST_W));
    check("ld_cnt", 32'(instr_count), 1);
    check("ld_mem40_kept", 32'(mem[8'h40]), 32'h33);

    // run held high throughout, then reset during a store's EXECA
    do_reset();
    mem[0] = 8'hC0; mem[1] = 8'h00; mem[2] = 8'h41; mem[3] = 8'h66;
    mem[8'h40] = 8'h33;
    run = 1'b1;
    step();
    check("rh_fa", 32'(stages()), 32'(ST_FA));
    step();
    check("rh_fb", 32'(stages()), 32'(ST_FB));
    step();
    check("rh_ea", 32'(stages()), 32'(ST_EA));
    step();
    check("rh_eb", 32'(stages()), 32'(ST_EB));
    check("rh_acc", 32'(acc), 32'h33);
    step();
    check_fetch("rh_fa2", ST_FA, 2);
    step();
    step();
    check("rh_ea2_wren", {30'd0, mem_rden, mem_wren}, 32'b01);
    check("rh_ea2_cnt", 32'(instr_count), 1);
    rst = 1'b1;
    step();
    check("mr_stage", 32'(stages()), 32'(ST_W));
    check("mr_wren", 32'(mem_wren), 0);
    check("mr_pc", 32'(pc), 0);
    check("mr_cnt", 32'(instr_count), 0);
    check("mr_acc", 32'(acc), 0);
    step();
    check("mr_run_rst_stage", 32'(stages()), 32'(ST_W));
    rst = 1'b0;
    run = 1'b0;
    step();
    check("mr_idle_stage", 32'(stages()), 32'(ST_W));

    // pc wrap with no halt
    for (int i = 0; i < (1 << ADDR_W); i += 2) begin
      mem[i] = 8'h10;
      mem[i+1] = 8'hAA;
    end
    mem[8'h7E] = 8'h11; mem[8'h7F] = 8'hBB;
    run = 1'b1;
    step();
    run = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (fetchb && mem_addr == 7'h7F) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("wr_found", 32'(found), 1);
    step();
    check("wr_ea_addr", 32'(mem_addr), 32'h11);
    check("wr_ea_wdata", 32'(mem_wdata), 32'hBB);
    step();
    check("wr_mem11", 32'(mem[8'h11]), 32'hBB);
    step();
    check_fetch("wr_fa0", ST_FA, 0);
    check("wr_cnt", 32'(instr_count), 64);
    do_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
MEM_SEQUENCER -- requirements
Module: mem_sequencer

Interface
REQ-001 Parameter DATA_W, default 8, memory word width in bits.
REQ-002 Parameter ADDR_W, default 7, memory address width; legal range 2..DATA_W-1.
REQ-003 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high (clk, rst).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 run  input  1  start request, sampled only in WAIT.
REQ-008 waits, fetcha, fetchb, execa, execb  output  1 each  one-hot stage indicators.
REQ-009 pc  output  ADDR_W  program counter.
REQ-010 ira, irb  output  DATA_W each  instruction registers A and B.
REQ-011 acc  output  DATA_W  load-result register.
REQ-012 halted  output  1  set when a halt word was fetched.
REQ-013 instr_count  output  CNT_W  retired store/load instructions.
REQ-014 mem_addr  output  ADDR_W  memory address bus.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_rden, mem_wren  output  1 each  memory read and write enables.
REQ-017 mem_rdata  input  DATA_W  read data, valid in the same cycle as mem_rden (negedge-clocked RAM).

Function
REQ-018 Instruction format: word A then word B. A[DATA_W-1] is op (0 store, 1 load). A[ADDR_W-1:0] is the target address. B is the store data and is ignored for load.
REQ-019 Halt word: A equal to all ones.
REQ-020 Stage FSM: WAIT->FETCHA on run. FETCHA->FETCHB. FETCHB->EXECA, or FETCHB->WAIT when ira is the halt word. EXECA->EXECB->FETCHA.
REQ-021 Exactly one stage output SHALL be 1 in every cycle.
REQ-022 FETCHA: mem_addr=pc, mem_rden=1; ira<=mem_rdata at cycle end; pc<=pc+1.
REQ-023 FETCHB: mem_addr=pc, mem_rden=1; irb<=mem_rdata; pc<=pc+1.
REQ-024 EXECA store: mem_addr=ira[ADDR_W-1:0], mem_wdata=irb, mem_wren=1, mem_rden=0.
REQ-025 EXECA load: mem_addr=ira[ADDR_W-1:0], mem_rden=1, mem_wren=0; acc<=mem_rdata at cycle end.
REQ-026 EXECB: no memory access; instr_count<=instr_count+1 at cycle end.
REQ-027 Outside the active cases of REQ-022..025, mem_rden=0, mem_wren=0, mem_addr=0 and mem_wdata=0.
REQ-028 mem_rden and mem_wren SHALL never both be 1.
REQ-029 pc wraps modulo 2^ADDR_W; an instruction straddling the wrap (A at max, B at 0) is legal.
REQ-030 instr_count wraps modulo 2^CNT_W; halt words are not counted.
REQ-031 Halt: on the FETCHB->WAIT transition, halted<=1. pc is retained, pointing past the halt pair, so a later run resumes there.
REQ-032 Accepting run in WAIT clears halted in the same edge.
REQ-033 run is ignored in all non-WAIT stages.
REQ-034 Latency: run sampled at edge N puts fetcha=1 in cycle N+1. Each non-halt instruction takes 4 cycles; a halt pair takes 2 cycles.

Reset
REQ-035 rst=1 at an edge SHALL force WAIT and zero pc, ira, irb, acc, halted and instr_count, from any stage.
REQ-036 After reset, waits=1, all other stage outputs are 0, and mem_rden=mem_wren=0.
REQ-037 rst has priority over run in the same cycle.
REQ-038 A write in progress in EXECA when rst is sampled SHALL be deasserted in the following cycle.

Verification (DATA_W=8, ADDR_W=7)
REQ-039 Store and halt: mem[0..3]=40,5A,FF,00, pulse run. Expected: FETCHA addr 0, FETCHB addr 1, EXECA wren addr 40 data 5A, EXECB, FETCHA addr 2, FETCHB addr 3, then WAIT with halted=1, pc=4, instr_count=1.
REQ-040 Load: mem[0..1]=C0,00, mem[40]=33, mem[2..3]=FF,00. Expected: EXECA has rden=1, wren=0, addr 40; then acc=33 and instr_count=1.
REQ-041 Resume: after REQ-039, set mem[4..5]=41,77 and mem[6..7]=FF,00, pulse run. Expected: halted clears, mem[41]=77 written, halt at pc=8, instr_count=2.
REQ-042 Wrap: all words are store 10,AA except mem[7E..7F]=11,BB; run with no halt. Expected: after FETCHB at addr 7F, the next FETCHA addresses 0, and mem[11]=BB is written.
REQ-043 Reset mid-op: assert rst during EXECA of a store. Expected next cycle: waits=1, wren=0, pc=0, instr_count=0, acc=0.
REQ-044 Contention: run held at 1 throughout execution does not disturb the sequence; run=1 with rst=1 leaves the block in WAIT.
